// File: rtl/pla_cube_eval_pkg.sv
// -----------------------------------------------------------------------------
// pla_eval_pkg
// Shared types for the programmable PLA cube evaluator:
//   state_t - evaluator FSM states
//   cube_t  - one product term: literal-present mask, literal polarity and
//             the output mask it contributes when it matches
//   clog2   - elaboration-time ceiling log2 (never less than 1)
// The cube_t field widths set the widest NUM_IN / NUM_OUT the evaluator
// supports; instances narrower than these zero-extend into the fields.
// -----------------------------------------------------------------------------
package pla_eval_pkg;

   localparam int CUBE_IN_W  = 10;
   localparam int CUBE_OUT_W = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [CUBE_IN_W-1:0]  care;
      logic [CUBE_IN_W-1:0]  val;
      logic [CUBE_OUT_W-1:0] out;
   } cube_t;

   // Ceiling log2, clamped to 1 so a one-entry table still gets an index bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((32'sd1 <<< w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pla_cube_eval_if.sv
// -----------------------------------------------------------------------------
// pla_cube_eval_if
// Bundles the programming, configuration, input-vector and result channels of
// the PLA cube evaluator.
//   prog_*      : cube table write port (prog_ready high only while idle)
//   cfg_*       : active cube count and per-output inversion, sampled at accept
//   in_valid/in_ready/x      : input vector handshake
//   out_valid/out_ready/y    : result handshake
// modport master : the side that programs the table and issues vectors
// modport slave  : the evaluator
// -----------------------------------------------------------------------------
interface pla_cube_eval_if #(
   parameter int NUM_IN    = 10,
   parameter int NUM_OUT   = 1,
   parameter int NUM_CUBES = 64
) ();

   localparam int AW = pla_eval_pkg::clog2(NUM_CUBES);
   localparam int CW = AW + 1;

   logic               prog_we;
   logic [AW-1:0]      prog_addr;
   logic [NUM_IN-1:0]  prog_care;
   logic [NUM_IN-1:0]  prog_val;
   logic [NUM_OUT-1:0] prog_out;
   logic               prog_ready;
   logic [CW-1:0]      cfg_ncubes;
   logic [NUM_OUT-1:0] cfg_out_inv;
   logic               in_valid;
   logic               in_ready;
   logic [NUM_IN-1:0]  x;
   logic               out_valid;
   logic               out_ready;
   logic [NUM_OUT-1:0] y;

   modport master (
      output prog_we, prog_addr, prog_care, prog_val, prog_out,
      output cfg_ncubes, cfg_out_inv,
      output in_valid, x, out_ready,
      input  prog_ready, in_ready, out_valid, y
   );

   modport slave (
      input  prog_we, prog_addr, prog_care, prog_val, prog_out,
      input  cfg_ncubes, cfg_out_inv,
      input  in_valid, x, out_ready,
      output prog_ready, in_ready, out_valid, y
   );

endinterface

// File: rtl/pla_cube_eval_match.sv
// -----------------------------------------------------------------------------
// pla_cube_match
// Combinational compare of one window of CUBES_PER_CYCLE cubes against the
// latched input vector.
//   x       : input vector
//   cubes   : window of cubes, entry j holds table index base+j
//   base    : table index of cubes[0]
//   ncubes  : active cube count; indices at or above it are ignored
//   hit_out : OR of the output masks of every matching, in-range cube
// -----------------------------------------------------------------------------
module pla_cube_match
   import pla_eval_pkg::*;
#(
   parameter int NUM_IN          = 10,
   parameter int NUM_OUT         = 1,
   parameter int CUBES_PER_CYCLE = 1,
   parameter int CW              = 7
) (
   input  logic [NUM_IN-1:0]                 x,
   input  cube_t [CUBES_PER_CYCLE-1:0]       cubes,
   input  logic [CW-1:0]                     base,
   input  logic [CW-1:0]                     ncubes,
   output logic [NUM_OUT-1:0]                hit_out
);

   logic [CUBE_IN_W-1:0] x_ext_s;

   assign x_ext_s = CUBE_IN_W'(x);

   // A cube matches when every present literal agrees with x; a cube with
   // no literals therefore always matches.
   always_comb begin
      hit_out = '0;
      for (int j = 0; j < CUBES_PER_CYCLE; j++) begin
         if ((((x_ext_s ^ cubes[j].val) & cubes[j].care) == '0) &&
             ((base + CW'(j)) < ncubes)) begin
            hit_out = hit_out | NUM_OUT'(cubes[j].out);
         end else begin
            hit_out = hit_out;
         end
      end
   end

endmodule

// File: rtl/pla_cube_eval.sv
// -----------------------------------------------------------------------------
// pla_cube_eval
// Programmable two-level (sum-of-products) function evaluator. A cube table
// is loaded at runtime; each accepted vector is compared against the first
// ncubes entries, CUBES_PER_CYCLE per clock, and the OR of the matching
// cubes' output masks is returned XORed with a per-output inversion mask.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset; drops any in-flight vector and
//          clears the cube table
//   bus  : pla_cube_eval_if slave (programming, config, in/out handshakes)
// -----------------------------------------------------------------------------
module pla_cube_eval
   import pla_eval_pkg::*;
#(
   parameter int NUM_IN          = 10,
   parameter int NUM_OUT         = 1,
   parameter int NUM_CUBES       = 64,
   parameter int CUBES_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   pla_cube_eval_if.slave   bus
);

   localparam int            AW         = clog2(NUM_CUBES);
   localparam int            CW         = AW + 1;
   localparam logic [CW-1:0] NCUBES_MAX = CW'(NUM_CUBES);
   localparam logic [CW-1:0] STEP       = CW'(CUBES_PER_CYCLE);

   state_t                         state_r;
   state_t                         state_nxt_s;
   logic [NUM_IN-1:0]              x_r;
   logic [CW-1:0]                  ncubes_r;
   logic [NUM_OUT-1:0]             inv_r;
   logic [NUM_OUT-1:0]             acc_r;
   logic [CW-1:0]                  ptr_r;
   cube_t                          table_r [NUM_CUBES];
   cube_t [CUBES_PER_CYCLE-1:0]    window_s;
   logic [CW-1:0]                  ncubes_clamp_s;
   logic [NUM_OUT-1:0]             hit_s;
   logic                           last_beat_s;
   logic                           accept_s;

   assign accept_s = (state_r == IDLE) && bus.in_valid;

   // The beat is last once the window reaches ncubes; one extra bit keeps
   // ptr+step from wrapping when ncubes equals the table depth.
   assign last_beat_s = ({1'b0, ptr_r} + {1'b0, STEP}) >= {1'b0, ncubes_r};

   // Requested cube counts beyond the table depth evaluate the whole table.
   always_comb begin
      if (bus.cfg_ncubes > NCUBES_MAX) begin
         ncubes_clamp_s = NCUBES_MAX;
      end else begin
         ncubes_clamp_s = bus.cfg_ncubes;
      end
   end

   // Select the current scan window. ptr_r is a multiple of the window size
   // and stays below the table depth while scanning, so the window never
   // straddles the end of the table.
   always_comb begin
      window_s = '0;
      for (int j = 0; j < CUBES_PER_CYCLE; j++) begin
         window_s[j] = table_r[ptr_r[AW-1:0] + AW'(j)];
      end
   end

   pla_cube_match #(
      .NUM_IN          (NUM_IN),
      .NUM_OUT         (NUM_OUT),
      .CUBES_PER_CYCLE (CUBES_PER_CYCLE),
      .CW              (CW)
   ) u_match (
      .x       (x_r),
      .cubes   (window_s),
      .base    (ptr_r),
      .ncubes  (ncubes_r),
      .hit_out (hit_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; an empty cube list skips straight to the result.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               if (ncubes_clamp_s == '0) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = SCAN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SCAN: begin
            if (last_beat_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SCAN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM outputs, decoded from registered state and accumulator only.
   always_comb begin
      bus.in_ready   = (state_r == IDLE);
      bus.prog_ready = (state_r == IDLE);
      bus.out_valid  = (state_r == DONE);
      if (state_r == DONE) begin
         bus.y = acc_r ^ inv_r;
      end else begin
         bus.y = '0;
      end
   end

   // Vector datapath: capture the vector and its configuration at accept so
   // later cfg changes cannot disturb it, then accumulate matches per beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r      <= '0;
         ncubes_r <= '0;
         inv_r    <= '0;
         acc_r    <= '0;
         ptr_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  x_r      <= bus.x;
                  ncubes_r <= ncubes_clamp_s;
                  inv_r    <= bus.cfg_out_inv;
                  acc_r    <= '0;
                  ptr_r    <= '0;
               end
            end
            SCAN: begin
               acc_r <= acc_r | hit_s;
               ptr_r <= ptr_r + STEP;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

   // Cube table: writable only while idle so a scan always sees a stable
   // table; reset clears every entry so no stale cube survives a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CUBES; i++) begin
            table_r[i] <= '0;
         end
      end else if (bus.prog_we && (state_r == IDLE)) begin
         table_r[bus.prog_addr] <= '{care: CUBE_IN_W'(bus.prog_care),
                                     val:  CUBE_IN_W'(bus.prog_val),
                                     out:  CUBE_OUT_W'(bus.prog_out)};
      end
   end

endmodule

// File: tb/tb_pla_cube_eval.sv
// -----------------------------------------------------------------------------
// tb_pla_cube_eval
// Directed bench for pla_cube_eval with NUM_CUBES=64, CUBES_PER_CYCLE=4.
// Expected results and latencies below are hand-derived from the cube
// contents programmed in each step.
// -----------------------------------------------------------------------------
module tb_pla_cube_eval;

   localparam int NUM_IN    = 10;
   localparam int NUM_OUT   = 1;
   localparam int NUM_CUBES = 64;
   localparam int CPC       = 4;

   logic clk;
   logic rst;
   int   ncmp;
   int   nerr;
   int   lat;

   pla_cube_eval_if #(
      .NUM_IN    (NUM_IN),
      .NUM_OUT   (NUM_OUT),
      .NUM_CUBES (NUM_CUBES)
   ) bus ();

   pla_cube_eval #(
      .NUM_IN          (NUM_IN),
      .NUM_OUT         (NUM_OUT),
      .NUM_CUBES       (NUM_CUBES),
      .CUBES_PER_CYCLE (CPC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic program_cube(input logic [5:0] a, input logic [9:0] c,
                               input logic [9:0] v, input logic o);
      bus.prog_we   = 1'b1;
      bus.prog_addr = a;
      bus.prog_care = c;
      bus.prog_val  = v;
      bus.prog_out  = o;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   task automatic accept(input logic [9:0] xv, input logic [6:0] nc, input logic inv);
      bus.x           = xv;
      bus.cfg_ncubes  = nc;
      bus.cfg_out_inv = inv;
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid    = 1'b0;
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_out(input string tag, output int l);
      l = 1;
      while (bus.out_valid !== 1'b1 && l < 100) begin
         tick();
         l++;
      end
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_ovalid_low"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_iready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run(input string tag, input logic [9:0] xv, input logic [6:0] nc,
                      input logic inv, input logic exp_y, input int exp_lat);
      int l;
      chk({tag, "_iready"}, 32'(bus.in_ready), 32'd1);
      accept(xv, nc, inv);
      wait_out(tag, l);
      chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
      chk({tag, "_y"}, 32'(bus.y), 32'(exp_y));
      release_out(tag);
   endtask

   initial begin
      ncmp            = 0;
      nerr            = 0;
      rst             = 1'b1;
      bus.prog_we     = 1'b0;
      bus.prog_addr   = 6'd0;
      bus.prog_care   = 10'd0;
      bus.prog_val    = 10'd0;
      bus.prog_out    = 1'b0;
      bus.cfg_ncubes  = 7'd0;
      bus.cfg_out_inv = 1'b0;
      bus.in_valid    = 1'b0;
      bus.x           = 10'd0;
      bus.out_ready   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_prog_ready", 32'(bus.prog_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);

      // Empty cube list: result is the inversion mask, one cycle after accept
      run("n0_inv1", 10'h000, 7'd0, 1'b1, 1'b1, 1);

      // Single fully specified cube
      program_cube(6'd0, 10'h3FF, 10'h155, 1'b1);
      run("c0_hit", 10'h155, 7'd1, 1'b0, 1'b1, 2);
      run("c0_miss", 10'h154, 7'd1, 1'b0, 1'b0, 2);

      // Only cube 9 matches x=0x2AA; cubes 1..8 have zero output masks
      program_cube(6'd9, 10'h3FF, 10'h2AA, 1'b1);
      run("n10_hit", 10'h2AA, 7'd10, 1'b0, 1'b1, 4);
      run("n9_masked", 10'h2AA, 7'd9, 1'b0, 1'b0, 4);
      run("n10_inv", 10'h2AA, 7'd10, 1'b1, 1'b0, 4);

      // Oversized count clamps to the full table (16 beats)
      run("clamp80", 10'h2AA, 7'd80, 1'b0, 1'b1, 17);
      run("full64", 10'h155, 7'd64, 1'b0, 1'b1, 17);

      // Back-pressure in DONE with an attempted overwrite of cube 9
      accept(10'h2AA, 7'd10, 1'b0);
      wait_out("hold", lat);
      chk("hold_lat", 32'(lat), 32'd4);
      for (int k = 0; k < 5; k++) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = 6'd9;
         bus.prog_care = 10'h000;
         bus.prog_val  = 10'h000;
         bus.prog_out  = 1'b0;
         tick();
         chk("hold_y", 32'(bus.y), 32'd1);
         chk("hold_ovalid", 32'(bus.out_valid), 32'd1);
         chk("hold_iready", 32'(bus.in_ready), 32'd0);
         chk("hold_pready", 32'(bus.prog_ready), 32'd0);
      end
      bus.prog_we = 1'b0;
      release_out("hold");
      run("after_hold", 10'h2AA, 7'd10, 1'b0, 1'b1, 4);

      // Config and x changes after accept must not affect the vector
      accept(10'h2AA, 7'd10, 1'b0);
      bus.cfg_ncubes  = 7'd9;
      bus.cfg_out_inv = 1'b1;
      bus.x           = 10'h000;
      chk("cfgchg_iready_scan", 32'(bus.in_ready), 32'd0);
      wait_out("cfgchg", lat);
      chk("cfgchg_lat", 32'(lat), 32'd4);
      chk("cfgchg_y", 32'(bus.y), 32'd1);
      release_out("cfgchg");

      // Reset during SCAN drops the vector and clears the table
      accept(10'h2AA, 7'd64, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #2;
      chk("rst_scan_ovalid", 32'(bus.out_valid), 32'd0);
      chk("rst_scan_iready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rel_iready", 32'(bus.in_ready), 32'd1);
      chk("rel_ovalid", 32'(bus.out_valid), 32'd0);
      run("cleared_inv1", 10'h2AA, 7'd64, 1'b1, 1'b1, 17);
      run("cleared_c0", 10'h155, 7'd1, 1'b0, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
